// File: rtl/mux2_arbiter_pkg.sv
// mux2_arbiter shared constants.
// State encodings and mux select values.
package mux2_arbiter_pkg;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] OWN_A = 2'b01;
  localparam logic [1:0] OWN_B = 2'b10;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  function automatic logic is_own(
    input logic [1:0] st
  );
    return (st == OWN_A) || (st == OWN_B);
  endfunction

endpackage

// File: rtl/mux2_arbiter_if.sv
// mux2_arbiter channel bundle.
// master = requester side, slave = arbiter.
interface mux2_arbiter_if #(
  parameter int W = 8
);

  logic         req_a;
  logic         req_b;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         gnt_a;
  logic         gnt_b;
  logic         s;
  logic [W-1:0] out;
  logic         out_valid;

  modport master (
    output req_a, req_b, a, b,
    input  gnt_a, gnt_b, s,
    input  out, out_valid
  );

  modport slave (
    input  req_a, req_b, a, b,
    output gnt_a, gnt_b, s,
    output out, out_valid
  );

endinterface

// File: rtl/mux2_arbiter_mux2_w.sv
// mux2_w: width-parameterised 2:1 mux.
// s=0 routes a, s=1 routes b.
module mux2_w #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         s,
  output logic [W-1:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/mux2_arbiter.sv
// mux2_arbiter: round-robin owner of a shared
// 2:1 datapath with bounded hold time.
module mux2_arbiter
  import mux2_arbiter_pkg::*;
#(
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input logic             clk,
  input logic             reset,
  mux2_arbiter_if.slave   bus
);

  localparam int CW =
    (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] CMAX =
    CW'(MAX_HOLD - 1);

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [CW-1:0] cnt;
  logic          last;
  logic          sel;
  logic          gnt;
  logic [W-1:0]  mux_y;
  logic [W-1:0]  out_q;
  logic          vld_q;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (bus.req_a && bus.req_b)
          state_nx = last ? OWN_A : OWN_B;
        else if (bus.req_a)
          state_nx = OWN_A;
        else if (bus.req_b)
          state_nx = OWN_B;
      end
      OWN_A: begin
        if (!bus.req_a)
          state_nx = bus.req_b ? OWN_B : IDLE;
        else if (bus.req_b && cnt == CMAX)
          state_nx = OWN_B;
      end
      OWN_B: begin
        if (!bus.req_b)
          state_nx = bus.req_a ? OWN_A : IDLE;
        else if (bus.req_a && cnt == CMAX)
          state_nx = OWN_A;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Fresh ownership restarts the hold count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      if (state_nx != state) begin
        cnt <= '0;
        if (is_own(state_nx))
          last <= (state_nx == OWN_B);
      end else if (is_own(state)) begin
        if (cnt != CMAX)
          cnt <= cnt + 1'b1;
      end
    end
  end

  assign sel = (state == OWN_B) ? SEL_B : SEL_A;
  assign gnt = is_own(state);

  mux2_w #(.W(W)) u_mux (
    .a (bus.a),
    .b (bus.b),
    .s (sel),
    .y (mux_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= gnt;
      if (gnt)
        out_q <= mux_y;
    end
  end

  assign bus.gnt_a     = (state == OWN_A);
  assign bus.gnt_b     = (state == OWN_B);
  assign bus.s         = sel;
  assign bus.out       = out_q;
  assign bus.out_valid = vld_q;

endmodule
